// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with flop-based storage.
// Hits return combinationally; misses stall the PC and refill one line word by word.
module icache_direct #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic             flush,
  output logic [WIDTH-1:0] instr,
  output logic             hit,
  output logic             stall,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_valid,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = WIDTH - IDX_W - OFF_W - 2;
  localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_e;

  state_e                  state_q;
  logic [SETS-1:0]         valid_q;
  logic [TAG_W-1:0]        tag_q  [SETS];
  logic [WIDTH-1:0]        data_q [SETS][LINE_WORDS];
  logic [TAG_W-1:0]        rtag_q;
  logic [IDX_W-1:0]        ridx_q;
  logic [OFF_W-1:0]        beat_q;

  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_off;
  logic             lookup_hit;
  logic             beat_fire;
  logic             unused_byte_bits;

  assign a_tag = addr[WIDTH-1 -: TAG_W];
  assign a_idx = addr[2+OFF_W +: IDX_W];
  assign a_off = addr[2 +: OFF_W];
  assign unused_byte_bits = ^addr[1:0];

  // Flush and reset both mask the lookup; reset additionally releases stall.
  assign lookup_hit = (state_q == IDLE) && valid_q[a_idx] && (tag_q[a_idx] == a_tag)
                      && !flush && !rst;
  assign beat_fire  = (state_q == REFILL) && mem_valid && !flush && !rst;

  assign hit      = lookup_hit;
  assign stall    = !rst && !lookup_hit;
  assign instr    = lookup_hit ? data_q[a_idx][a_off] : NOP;
  assign mem_req  = (state_q == REFILL) && !rst;
  assign mem_addr = mem_req ? {rtag_q, ridx_q, beat_q, 2'b00} : '0;

  // Control state: FSM, valid bits, latched refill line and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      beat_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!lookup_hit) begin
            state_q <= REFILL;
            rtag_q  <= a_tag;
            ridx_q  <= a_idx;
            beat_q  <= '0;
          end
        end
        REFILL: begin
          if (mem_valid) begin
            beat_q <= beat_q + OFF_W'(1);
            if (beat_q == LAST_BEAT) begin
              valid_q[ridx_q] <= 1'b1;
              state_q         <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // Tag and data arrays are never reset; only the valid bits gate them.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      data_q[ridx_q][beat_q] <= mem_rdata;
      if (beat_q == LAST_BEAT) begin
        tag_q[ridx_q] <= rtag_q;
      end
    end
  end

endmodule
